// File: rtl/fod_phase_ctrl.sv
// Phase-selection controller for the fractional output divider: accumulates a
// fractional FCW in 1/8-period steps and drives a one-hot phase select plus DTC code.
module fod_phase_ctrl #(
  parameter int unsigned FCW_IW = 4,
  parameter int unsigned FCW_FW = 16,
  parameter int unsigned DTC_W  = 6
) (
  input  logic                     CLK,
  input  logic                     ARST,
  input  logic                     EN,
  input  logic [FCW_IW+FCW_FW-1:0] FCW_IN,
  input  logic                     FCW_LD,
  output logic                     FCW_ACK,
  output logic                     FCW_ERR,
  output logic [7:0]               PHSEL,
  output logic [DTC_W-1:0]         DTC_CODE,
  output logic                     PH_WRAP,
  output logic                     RUN
);

  localparam int unsigned SW = FCW_IW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FCW_IW-1:0]   fcw_int_q, fcw_int_d;
  logic [FCW_FW-1:0]   fcw_frac_q, fcw_frac_d;
  logic [FCW_FW-1:0]   acc_q, acc_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [7:0]          phsel_q, phsel_d;
  logic [DTC_W-1:0]    dtc_q, dtc_d;
  logic                wrap_q, wrap_d;
  logic                run_q, run_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;

  logic [FCW_IW-1:0]   ld_int;
  logic [FCW_FW-1:0]   ld_frac;
  logic [FCW_FW:0]     sum;
  logic [SW-1:0]       step;

  // Next-state, shadow FCW load and registered-output computation
  always_comb begin
    state_d    = state_q;
    fcw_int_d  = fcw_int_q;
    fcw_frac_d = fcw_frac_q;
    acc_d      = '0;
    ptr_d      = '0;
    phsel_d    = 8'h01;
    dtc_d      = '0;
    wrap_d     = 1'b0;
    run_d      = 1'b0;

    ld_int  = FCW_IN[FCW_IW+FCW_FW-1:FCW_FW];
    ld_frac = FCW_IN[FCW_FW-1:0];
    ack_d   = FCW_LD && (ld_int != '0);
    err_d   = FCW_LD && (ld_int == '0);
    if (ack_d) begin
      fcw_int_d  = ld_int;
      fcw_frac_d = ld_frac;
    end

    sum  = (FCW_FW+1)'(acc_q) + (FCW_FW+1)'(fcw_frac_q);
    step = SW'(ptr_q) + SW'(fcw_int_q) + SW'(sum[FCW_FW]);

    if (!EN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end
        ST_RUN: begin
          acc_d   = sum[FCW_FW-1:0];
          ptr_d   = step[2:0];
          wrap_d  = (step >= SW'(8));
          phsel_d = 8'h01 << ptr_d;
          dtc_d   = acc_d[FCW_FW-1 -: DTC_W];
          run_d   = 1'b1;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q    <= ST_IDLE;
      fcw_int_q  <= FCW_IW'(1);
      fcw_frac_q <= '0;
      acc_q      <= '0;
      ptr_q      <= '0;
      phsel_q    <= 8'h01;
      dtc_q      <= '0;
      wrap_q     <= 1'b0;
      run_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcw_int_q  <= fcw_int_d;
      fcw_frac_q <= fcw_frac_d;
      acc_q      <= acc_d;
      ptr_q      <= ptr_d;
      phsel_q    <= phsel_d;
      dtc_q      <= dtc_d;
      wrap_q     <= wrap_d;
      run_q      <= run_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign FCW_ACK  = ack_q;
  assign FCW_ERR  = err_q;
  assign PHSEL    = phsel_q;
  assign DTC_CODE = dtc_q;
  assign PH_WRAP  = wrap_q;
  assign RUN      = run_q;

endmodule

// File: doc/fod_phase_ctrl.md
# fod_phase_ctrl

Phase-selection controller for the fractional output divider (FOD). It sits directly downstream of the 8-phase multi-phase divider and runs on the same CLK. Each cycle it accumulates a fractional frequency control word (FCW), measured in 1/8-period phase steps. From that it produces a registered one-hot select for the 8-phase output mux, a 6-bit DTC fine-delay code and a wrap flag. New FCW values are taken through a load/ack handshake.

## Interface
- FCW_IW, 4, integer bits of FCW (phase steps per cycle)
- FCW_FW, 16, fractional bits of FCW; must be ≥ DTC_W
- DTC_W, 6, width of DTC fine-delay code
- CLK  in  1  clock; all logic on rising edge
- ARST  in  1  asynchronous, active-high reset; one clock only
- EN  in  1  run enable (level)
- FCW_IN  in  FCW_IW+FCW_FW  FCW value; integer field is the MSBs
- FCW_LD  in  1  FCW load request, single-cycle pulse
- FCW_ACK  out  1  one-cycle pulse: FCW_IN accepted
- FCW_ERR  out  1  one-cycle pulse: FCW_IN rejected (integer field = 0)
- PHSEL  out  8  one-hot phase select (bit k selects phase k)
- DTC_CODE  out  DTC_W  fine delay, equal to the accumulator residue MSBs
- PH_WRAP  out  1  high when the phase pointer crossed 7→0 this step
- RUN  out  1  high while the state is RUN

## Operation
- State register holds fcw_int[FCW_IW], fcw_frac[FCW_FW], acc[FCW_FW], ptr[3] and state {IDLE, PRIME, RUN}.
- IDLE:
  - ptr=0, acc=0.
  - Goes to PRIME on the edge where EN=1.
- PRIME:
  - Clears acc and ptr; lasts one cycle.
  - Goes to RUN on the next edge if EN=1, otherwise back to IDLE.
- RUN, every edge:
  - {c, acc} = acc + fcw_frac. Unsigned; c is the carry out of FCW_FW bits.
  - s = ptr + fcw_int + c, computed FCW_IW+1 bits wide.
  - ptr = s mod 8.
  - PH_WRAP = (s ≥ 8).
- Any state with EN=0 sampled: go to IDLE next edge.
- FCW load:
  - FCW_LD=1 with FCW_IN integer field ≠ 0: shadow fcw_int/fcw_frac loaded on that edge; FCW_ACK=1 the following cycle.
  - Integer field = 0: shadow unchanged; FCW_ERR=1 the following cycle.
  - Loads are accepted in any state.
  - FCW_LD held high several cycles counts as one request per cycle; the last one wins.
- Outputs, all registered:
  - PHSEL = one-hot(ptr).
  - DTC_CODE = acc[FCW_FW-1 -: DTC_W].
  - RUN = (state==RUN).
  - In IDLE and PRIME: PHSEL=8'h01, DTC_CODE=0, PH_WRAP=0.
- FCW_IN integer values ≥ 8 are legal.
  - Pointer arithmetic is mod 8.
  - PH_WRAP asserts whenever s ≥ 8, including multiple wraps in one step.

## Timing
- ARST asserted, asynchronously:
  - State = IDLE.
  - fcw_int=1, fcw_frac=0, acc=0, ptr=0.
  - PHSEL=8'h01, DTC_CODE=0, PH_WRAP=0, RUN=0, FCW_ACK=0, FCW_ERR=0.
- ARST deasserted: first active edge is the next CLK rise.
- EN rises before edge e0:
  - PRIME after e0, RUN after e1 (RUN=1 from e1).
  - The first accumulation result is visible after e2.
  - Step k is visible after edge e(k+1).
- FCW_LD sampled at edge n:
  - FCW_ACK/FCW_ERR high between n and n+1.
  - The first accumulation using the new FCW happens at edge n+1.
- FCW_LD at the same edge as the IDLE→PRIME transition: PRIME and all RUN steps use the new FCW.
- EN falls, sampled at edge m:
  - State = IDLE after m.
  - Outputs at reset values after m; no further accumulation at m.
- ARST mid-RUN: immediate return to reset values. Any pending ACK/ERR is dropped, and the shadow FCW returns to 1.0.
- Latency from FCW/accumulator state to PHSEL: exactly one register stage; no combinational path from inputs to outputs.

## Test plan
- Reset check: ARST pulse mid-RUN with FCW=2.5 → all outputs at reset values immediately; FCW reads back as 1.0, i.e. a subsequent run steps ptr 0,1,2,…
- FCW=1.5 (int=1, frac=0x8000), EN rise:
  - PHSEL pointer sequence after PRIME is 1,3,4,6,7,1,2,4.
  - DTC_CODE sequence is 32,0,32,0,32,0,32,0.
  - PH_WRAP=1 only on the step 7→1.
- FCW=1.25:
  - ptr sequence 1,2,3,5,6,7,0,2.
  - DTC_CODE sequence 16,32,48,0,….
  - PH_WRAP on the step 7→0.
- Handshake:
  - FCW_LD with int=0 → FCW_ERR pulse one cycle later, no ACK, ptr stepping unchanged.
  - FCW_LD with 3.0 → FCW_ACK pulse, and ptr advances by 3 starting from the next step.
- FCW=9.0: ptr advances by 1 each step, and PH_WRAP=1 on every step.
- EN low for one cycle mid-RUN → IDLE then PRIME then RUN; ptr restarts from 0; PHSEL=8'h01 during the gap.
